// File: rtl/gsm_resp_rx_if.sv
// -----------------------------------------------------------------------------
// gsm_resp_rx_if
// Groups the GSM modem receive line and the parsed-response outputs of
// gsm_resp_rx.
//   slave  : the receiver (takes gsm_rx, drives bytes and response strobes)
//   master : the environment (drives gsm_rx, observes bytes and strobes)
// Signals:
//   gsm_rx       serial line from the modem TX pin, idle high, 8N1, LSB first
//   rx_valid     one-cycle strobe, rx_byte valid
//   rx_byte      last received byte
//   resp_ok      one-cycle strobe, line "OK"
//   resp_error   one-cycle strobe, "ERROR" or "+CME ERROR:"/"+CMS ERROR:" line
//   resp_prompt  one-cycle strobe, "> " at start of line
//   resp_ring    one-cycle strobe, line "RING"
//   resp_cmti    one-cycle strobe, line starting "+CMTI:"
//   sms_index    storage index from the last +CMTI line
//   frame_err    one-cycle strobe, stop bit sampled low
//   line_ovf     one-cycle strobe, terminated line exceeded the buffer
// -----------------------------------------------------------------------------
interface gsm_resp_rx_if;
    logic       gsm_rx;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       resp_ok;
    logic       resp_error;
    logic       resp_prompt;
    logic       resp_ring;
    logic       resp_cmti;
    logic [7:0] sms_index;
    logic       frame_err;
    logic       line_ovf;

    modport master (
        output gsm_rx,
        input  rx_valid, rx_byte, resp_ok, resp_error, resp_prompt,
        input  resp_ring, resp_cmti, sms_index, frame_err, line_ovf
    );

    modport slave (
        input  gsm_rx,
        output rx_valid, rx_byte, resp_ok, resp_error, resp_prompt,
        output resp_ring, resp_cmti, sms_index, frame_err, line_ovf
    );
endinterface

// File: rtl/gsm_resp_rx.sv
// -----------------------------------------------------------------------------
// gsm_resp_rx
// Receive side of the GSM modem link. Deserialises the modem UART TX line
// (8N1, LSB first) and parses AT result lines into one-cycle response strobes
// so the SMS/call sequencers can pace their command streams.
//
// Parameters:
//   CLK_FREQ  system clock in Hz
//   BAUD      serial rate; one bit lasts CLK_FREQ/BAUD clocks
//   MAX_LINE  line-buffer depth in bytes (up to 255)
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   gsm_resp_rx_if.slave: gsm_rx in; rx_valid/rx_byte, response
//         strobes, sms_index, frame_err, line_ovf out (all registered)
// Build option:
//   GSM_CMTI_INDEX_EN  when defined, the decimal index after the last ','
//                      of a +CMTI line is captured into sms_index
//                      (saturating at 255); otherwise sms_index is 0.
// -----------------------------------------------------------------------------
module gsm_resp_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int MAX_LINE = 16
) (
    input  logic         clk,
    input  logic         rst,
    gsm_resp_rx_if.slave bus
);
    localparam int               BIT_CYC  = CLK_FREQ / BAUD;
    localparam int               CNT_W    = (BIT_CYC > 32'sd2) ? $clog2(BIT_CYC) : 32'sd1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(BIT_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_CYC / 32'sd2);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [7:0]       MAX_LEN  = 8'(MAX_LINE);
    // Only the first 11 characters ("+CME ERROR:") can decide a match, so
    // only those are kept; the length counter still tracks the full line.
    localparam int               KEEP_D   = 11;
    localparam logic [87:0]      PFX_CME  = 88'h2B434D45204552524F523A; // "+CME ERROR:"
    localparam logic [87:0]      PFX_CMS  = 88'h2B434D53204552524F523A; // "+CMS ERROR:"

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    logic             sync1_r, sync2_r, rx_prev_r;
    uart_state_t      state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [2:0]       bit_r, bit_s;
    logic [7:0]       shift_r, shift_s;
    logic             byte_ok_s, byte_bad_s;

    logic             rx_valid_r, frame_err_r;
    logic [7:0]       rx_byte_r;

    logic [7:0]       line_r [KEEP_D];
    logic [7:0]       len_r;
    logic             ovf_r;
    logic [87:0]      pfx_s;
    logic             m_ok_s, m_err_s, m_ring_s, m_cmti_s;
    logic             is_cr_s, is_lf_s, is_prompt_s;
    logic             term_s, prompt_s, data_s, line_clr_s, judge_s, ovf_evt_s;
    logic             resp_ok_r, resp_error_r, resp_prompt_r, resp_ring_r;
    logic             resp_cmti_r, line_ovf_r;

    // Two-flop synchroniser plus one delayed copy for start-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            sync1_r   <= bus.gsm_rx;
            sync2_r   <= sync1_r;
            rx_prev_r <= sync2_r;
        end
    end

    // UART FSM next-state, bit timing and shift logic
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        byte_ok_s  = 1'b0;
        byte_bad_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = CNT_ZERO;
                bit_s = 3'd0;
                if (rx_prev_r && !sync2_r) begin
                    state_s = ST_START;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                // Mid-start-bit recheck rejects glitches shorter than half a bit
                if (cnt_r == CNT_HALF) begin
                    cnt_s = CNT_ZERO;
                    if (sync2_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_TERM) begin
                    cnt_s   = CNT_ZERO;
                    shift_s = {sync2_r, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        bit_s   = 3'd0;
                        state_s = ST_STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_TERM) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_IDLE;
                    if (sync2_r) begin
                        byte_ok_s = 1'b1;
                    end else begin
                        byte_bad_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                bit_s   = 3'd0;
            end
        endcase
    end

    // UART FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
        end
    end

    // Byte output register: rx_byte holds until the next good frame
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
            rx_byte_r   <= 8'd0;
        end else begin
            rx_valid_r  <= byte_ok_s;
            frame_err_r <= byte_bad_s;
            if (byte_ok_s) begin
                rx_byte_r <= shift_r;
            end
        end
    end

    // Line decode: pattern matches on the stored prefix and per-byte class
    always_comb begin
        pfx_s       = {line_r[0], line_r[1], line_r[2], line_r[3], line_r[4], line_r[5],
                       line_r[6], line_r[7], line_r[8], line_r[9], line_r[10]};
        m_ok_s      = (len_r == 8'd2) && (pfx_s[87:72] == 16'h4F4B);          // "OK"
        m_err_s     = ((len_r == 8'd5) && (pfx_s[87:48] == 40'h4552524F52))    // "ERROR"
                   || ((len_r >= 8'd11) && ((pfx_s == PFX_CME) || (pfx_s == PFX_CMS)));
        m_ring_s    = (len_r == 8'd4) && (pfx_s[87:56] == 32'h52494E47);        // "RING"
        m_cmti_s    = (len_r >= 8'd6) && (pfx_s[87:40] == 48'h2B434D54493A);    // "+CMTI:"
        is_cr_s     = (rx_byte_r == 8'h0D);
        is_lf_s     = (rx_byte_r == 8'h0A);
        // The modem sends "> " with no LF, so the space itself ends the line
        is_prompt_s = (rx_byte_r == 8'h20) && (len_r == 8'd1)
                   && (pfx_s[87:80] == 8'h3E) && !ovf_r;
        term_s      = rx_valid_r && is_lf_s;
        prompt_s    = rx_valid_r && is_prompt_s;
        data_s      = rx_valid_r && !is_cr_s && !is_lf_s && !is_prompt_s;
        line_clr_s  = frame_err_r || term_s || prompt_s;
        judge_s     = term_s && (len_r != 8'd0) && !ovf_r;
        ovf_evt_s   = term_s && (len_r != 8'd0) && ovf_r;
    end

    // Line buffer, overflow tracking and registered response strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            len_r         <= 8'd0;
            ovf_r         <= 1'b0;
            resp_ok_r     <= 1'b0;
            resp_error_r  <= 1'b0;
            resp_prompt_r <= 1'b0;
            resp_ring_r   <= 1'b0;
            resp_cmti_r   <= 1'b0;
            line_ovf_r    <= 1'b0;
            for (int i = 0; i < KEEP_D; i++) begin
                line_r[i] <= 8'd0;
            end
        end else begin
            resp_ok_r     <= judge_s && m_ok_s;
            resp_error_r  <= judge_s && m_err_s;
            resp_ring_r   <= judge_s && m_ring_s;
            resp_cmti_r   <= judge_s && m_cmti_s;
            resp_prompt_r <= prompt_s;
            line_ovf_r    <= ovf_evt_s;
            if (line_clr_s) begin
                len_r <= 8'd0;
                ovf_r <= 1'b0;
            end else if (data_s) begin
                if (len_r < MAX_LEN) begin
                    for (int i = 0; i < KEEP_D; i++) begin
                        if (len_r == 8'(i)) begin
                            line_r[i] <= rx_byte_r;
                        end
                    end
                    len_r <= len_r + 8'd1;
                end else begin
                    ovf_r <= 1'b1;
                end
            end
        end
    end

`ifdef GSM_CMTI_INDEX_EN
    logic [7:0] idx_r, sms_index_r;
    logic       comma_r;

    function automatic logic [7:0] idx_step(input logic [7:0] acc, input logic [3:0] digit);
        logic [11:0] sum_s;
        sum_s = ({4'd0, acc} * 12'd10) + {8'd0, digit};
        if (sum_s > 12'd255) begin
            idx_step = 8'd255;
        end else begin
            idx_step = sum_s[7:0];
        end
    endfunction

    // Decimal index accumulator after the last comma; latched on a +CMTI line.
    // Runs on every stored-or-dropped byte so buffer overflow does not affect it.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r       <= 8'd0;
            comma_r     <= 1'b0;
            sms_index_r <= 8'd0;
        end else begin
            if (judge_s && m_cmti_s) begin
                sms_index_r <= idx_r;
            end
            if (line_clr_s) begin
                idx_r   <= 8'd0;
                comma_r <= 1'b0;
            end else if (data_s) begin
                if (rx_byte_r == 8'h2C) begin
                    idx_r   <= 8'd0;
                    comma_r <= 1'b1;
                end else if (comma_r && (rx_byte_r >= 8'h30) && (rx_byte_r <= 8'h39)) begin
                    idx_r <= idx_step(idx_r, rx_byte_r[3:0]);
                end
            end
        end
    end

    assign bus.sms_index = sms_index_r;
`else
    assign bus.sms_index = 8'd0;
`endif

    assign bus.rx_valid    = rx_valid_r;
    assign bus.rx_byte     = rx_byte_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.resp_ok     = resp_ok_r;
    assign bus.resp_error  = resp_error_r;
    assign bus.resp_prompt = resp_prompt_r;
    assign bus.resp_ring   = resp_ring_r;
    assign bus.resp_cmti   = resp_cmti_r;
    assign bus.line_ovf    = line_ovf_r;
endmodule

// File: tb/tb_gsm_resp_rx.sv
// -----------------------------------------------------------------------------
// tb_gsm_resp_rx
// Directed self-checking bench for gsm_resp_rx. Runs at 16 clocks per bit
// (CLK_FREQ 160 kHz, BAUD 10 k) to keep the run short. A negedge monitor
// counts strobes and records the strobe-to-rx_valid distance; each test task
// compares those against hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_gsm_resp_rx;
    localparam int CLK_FREQ = 160_000;
    localparam int BAUD     = 10_000;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int MAX_LINE = 16;
`ifdef GSM_CMTI_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gsm_resp_rx_if bus();

    gsm_resp_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .MAX_LINE(MAX_LINE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0, last_valid_cyc = 0;
    int n_valid = 0, n_ok = 0, n_err = 0, n_prompt = 0, n_ring = 0;
    int n_cmti = 0, n_ferr = 0, n_ovf = 0;
    int lat_ok = 0, lat_err = 0, lat_prompt = 0, lat_ring = 0, lat_cmti = 0;
    logic [7:0] cmti_idx = 8'd0;
    logic [7:0] rx_log[$];

    // Observe outputs away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (bus.rx_valid === 1'b1) begin
            n_valid++;
            last_valid_cyc = cyc;
            rx_log.push_back(bus.rx_byte);
        end
        if (bus.resp_ok === 1'b1)     begin n_ok++;     lat_ok     = cyc - last_valid_cyc; end
        if (bus.resp_error === 1'b1)  begin n_err++;    lat_err    = cyc - last_valid_cyc; end
        if (bus.resp_prompt === 1'b1) begin n_prompt++; lat_prompt = cyc - last_valid_cyc; end
        if (bus.resp_ring === 1'b1)   begin n_ring++;   lat_ring   = cyc - last_valid_cyc; end
        if (bus.resp_cmti === 1'b1)   begin n_cmti++;   lat_cmti   = cyc - last_valid_cyc; cmti_idx = bus.sms_index; end
        if (bus.frame_err === 1'b1)   n_ferr++;
        if (bus.line_ovf === 1'b1)    n_ovf++;
    end

    function automatic int resp_total();
        return n_ok + n_err + n_prompt + n_ring + n_cmti + n_ferr + n_ovf;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.gsm_rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.gsm_rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        bus.gsm_rx = stop_bit;
        repeat (BIT_CYC) @(negedge clk);
        bus.gsm_rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i], 1'b1);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        int v0;
        bus.gsm_rx = 1'b1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        v0 = n_valid;
        repeat (2 * BIT_CYC) @(negedge clk);
        n_checks++;
        if ({bus.rx_valid, bus.resp_ok, bus.resp_error, bus.resp_prompt, bus.resp_ring,
             bus.resp_cmti, bus.frame_err, bus.line_ovf} !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b required 00000000", {bus.rx_valid, bus.resp_ok,
                     bus.resp_error, bus.resp_prompt, bus.resp_ring, bus.resp_cmti, bus.frame_err, bus.line_ovf});
        end
        n_checks++;
        if ({bus.rx_byte, bus.sms_index} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got rx_byte %h sms_index %h required 00 00", bus.rx_byte, bus.sms_index);
        end
        n_checks++;
        if (n_valid - v0 !== 0) begin
            n_fail++;
            $display("FAIL reset_idle_valid: got %0d rx_valid required 0", n_valid - v0);
        end
    endtask

    task automatic test_ok();
        int v0, s0, ok0, t0;
        logic [31:0] got;
        v0 = n_valid; s0 = rx_log.size(); ok0 = n_ok; t0 = resp_total();
        send_str("OK\r\n");
        got = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (s0 + i < rx_log.size()) got = {got[23:0], rx_log[s0 + i]};
        end
        n_checks++;
        if (n_valid - v0 !== 4) begin
            n_fail++; $display("FAIL ok_valid_count: got %0d required 4", n_valid - v0);
        end
        n_checks++;
        if (got !== 32'h4F4B0D0A) begin
            n_fail++; $display("FAIL ok_bytes: got %h required 4f4b0d0a", got);
        end
        n_checks++;
        if (n_ok - ok0 !== 1) begin
            n_fail++; $display("FAIL ok_strobe: got %0d required 1", n_ok - ok0);
        end
        n_checks++;
        if (lat_ok !== 1) begin
            n_fail++; $display("FAIL ok_latency: got %0d required 1", lat_ok);
        end
        n_checks++;
        if (resp_total() - t0 !== 1) begin
            n_fail++; $display("FAIL ok_other_strobes: got %0d total required 1", resp_total() - t0);
        end
        n_checks++;
        if (bus.rx_byte !== 8'h0A) begin
            n_fail++; $display("FAIL ok_rx_byte_hold: got %h required 0a", bus.rx_byte);
        end
    endtask

    task automatic test_prompt_error();
        int p0, e0, t0;
        p0 = n_prompt; t0 = resp_total();
        send_str("\r\n> ");
        n_checks++;
        if (n_prompt - p0 !== 1) begin
            n_fail++; $display("FAIL prompt_strobe: got %0d required 1", n_prompt - p0);
        end
        n_checks++;
        if (lat_prompt !== 1 || resp_total() - t0 !== 1) begin
            n_fail++; $display("FAIL prompt_timing: got latency %0d total %0d required 1 1", lat_prompt, resp_total() - t0);
        end
        e0 = n_err; t0 = resp_total();
        send_str("+CMS ERROR: 500\r\n");
        n_checks++;
        if (n_err - e0 !== 1 || resp_total() - t0 !== 1) begin
            n_fail++; $display("FAIL cms_error: got %0d error total %0d required 1 1", n_err - e0, resp_total() - t0);
        end
        n_checks++;
        if (lat_err !== 1) begin
            n_fail++; $display("FAIL error_latency: got %0d required 1", lat_err);
        end
        e0 = n_err;
        send_str("ERROR\r\n");
        n_checks++;
        if (n_err - e0 !== 1) begin
            n_fail++; $display("FAIL error_exact: got %0d required 1", n_err - e0);
        end
        t0 = resp_total();
        send_str("ERRORS\r\nOKAY\r\n");
        n_checks++;
        if (resp_total() - t0 !== 0) begin
            n_fail++; $display("FAIL near_miss_lines: got %0d strobes required 0", resp_total() - t0);
        end
    endtask

    task automatic test_cmti();
        int c0, o0;
        c0 = n_cmti;
        send_str("+CMTI: \"SM\",12\r\n");
        n_checks++;
        if (n_cmti - c0 !== 1 || lat_cmti !== 1) begin
            n_fail++; $display("FAIL cmti_strobe: got %0d latency %0d required 1 1", n_cmti - c0, lat_cmti);
        end
        n_checks++;
        if (cmti_idx !== (IDX_EN ? 8'd12 : 8'd0)) begin
            n_fail++; $display("FAIL cmti_index_12: got %0d required %0d", cmti_idx, IDX_EN ? 12 : 0);
        end
        send_str("+CMTI: \"SM\",300\r\n");
        n_checks++;
        if (cmti_idx !== (IDX_EN ? 8'd255 : 8'd0)) begin
            n_fail++; $display("FAIL cmti_index_sat: got %0d required %0d", cmti_idx, IDX_EN ? 255 : 0);
        end
        // Exactly MAX_LINE characters: no overflow, still a +CMTI line
        c0 = n_cmti; o0 = n_ovf;
        send_str("+CMTI: \"SM\",7,45\r\n");
        n_checks++;
        if (n_cmti - c0 !== 1 || n_ovf - o0 !== 0) begin
            n_fail++; $display("FAIL cmti_full_line: got cmti %0d ovf %0d required 1 0", n_cmti - c0, n_ovf - o0);
        end
        n_checks++;
        if (bus.sms_index !== (IDX_EN ? 8'd45 : 8'd0)) begin
            n_fail++; $display("FAIL cmti_last_comma: got %0d required %0d", bus.sms_index, IDX_EN ? 45 : 0);
        end
    endtask

    task automatic test_overflow();
        int o0, r0, t0;
        o0 = n_ovf; t0 = resp_total();
        for (int i = 0; i < 20; i++) send_byte(8'h41, 1'b1);
        send_str("\r\n");
        n_checks++;
        if (n_ovf - o0 !== 1 || resp_total() - t0 !== 1) begin
            n_fail++; $display("FAIL ovf_20a: got ovf %0d total %0d required 1 1", n_ovf - o0, resp_total() - t0);
        end
        r0 = n_ring; t0 = resp_total();
        send_str("RING\r\n");
        n_checks++;
        if (n_ring - r0 !== 1 || lat_ring !== 1 || resp_total() - t0 !== 1) begin
            n_fail++; $display("FAIL ring_after_ovf: got %0d latency %0d total %0d required 1 1 1",
                               n_ring - r0, lat_ring, resp_total() - t0);
        end
        o0 = n_ovf; t0 = resp_total();
        send_str("+CMTI: \"SM\",12345\r\n");
        n_checks++;
        if (n_ovf - o0 !== 1 || resp_total() - t0 !== 1) begin
            n_fail++; $display("FAIL ovf_17_chars: got ovf %0d total %0d required 1 1", n_ovf - o0, resp_total() - t0);
        end
    endtask

    task automatic test_frame_err();
        int f0, v0, t0;
        f0 = n_ferr; v0 = n_valid; t0 = resp_total();
        send_byte(8'h4F, 1'b1);
        send_byte(8'h4F, 1'b0);
        send_str("K\r\n");
        n_checks++;
        if (n_ferr - f0 !== 1) begin
            n_fail++; $display("FAIL frame_err_strobe: got %0d required 1", n_ferr - f0);
        end
        n_checks++;
        if (n_valid - v0 !== 4) begin
            n_fail++; $display("FAIL frame_err_valid: got %0d required 4", n_valid - v0);
        end
        // The bad frame must have cleared the pending "O", so "K" alone is no match
        n_checks++;
        if (resp_total() - t0 !== 1) begin
            n_fail++; $display("FAIL frame_err_line_clear: got %0d strobes required 1", resp_total() - t0);
        end
    endtask

    task automatic test_glitch();
        int v0, t0;
        v0 = n_valid; t0 = resp_total();
        bus.gsm_rx = 1'b0;
        repeat (5) @(negedge clk);
        bus.gsm_rx = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk);
        n_checks++;
        if (n_valid - v0 !== 0 || resp_total() - t0 !== 0) begin
            n_fail++; $display("FAIL glitch: got valid %0d strobes %0d required 0 0", n_valid - v0, resp_total() - t0);
        end
    endtask

    task automatic test_reset_mid();
        int ok0, t0;
        send_byte(8'h41, 1'b1);
        bus.gsm_rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        bus.gsm_rx = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT_CYC) @(negedge clk);
        n_checks++;
        if (bus.rx_byte !== 8'h00) begin
            n_fail++; $display("FAIL reset_mid_rx_byte: got %h required 00", bus.rx_byte);
        end
        ok0 = n_ok; t0 = resp_total();
        send_str("OK\r\n");
        n_checks++;
        if (n_ok - ok0 !== 1 || resp_total() - t0 !== 1) begin
            n_fail++; $display("FAIL reset_mid_ok: got %0d ok total %0d required 1 1", n_ok - ok0, resp_total() - t0);
        end
    endtask

    initial begin
        test_reset();
        test_ok();
        test_prompt_error();
        test_cmti();
        test_overflow();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
